gate_link_node: RTL and testbench

Per-gate datapath endpoint driven by the gate-array sequencer. One instance per gate: GATE_NUMBER nodes are chained ring-fashion, serial out of one into serial in of the next. Each node serializes a locally queued word on the sequencer's tx-start pulse, deserializes the word arriving from its upstream neighbour, and reports `o_tx_ready`/`o_rx_ready`. The sequencer ANDs these across gates and answers with `i_rx_pull`/`i_tx_start`.

---
 rtl/gate_link_pkg.sv | 16 +
 rtl/gate_link_node_fifo.sv | 55 +++++
 rtl/gate_link_node.sv | 179 +++++++++++++++++
 tb/tb_gate_link_node.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_link_pkg.sv
// Shared constants and types for the gate-array serial link node.
package gate_link_pkg;

    localparam int GL_DATA_WIDTH = 8;
    localparam int GL_FIFO_DEPTH = 4;
    localparam int GL_MAX_WIDTH  = 64;

    // Filler word sent when the sequencer starts a frame on an empty TX FIFO.
    localparam logic [GL_MAX_WIDTH-1:0] GL_IDLE_WORD = '0;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_e;

endpackage

// File: rtl/gate_link_node_fifo.sv
// Show-ahead synchronous FIFO with count-based flags; push and pop may coincide at any fill level.
module gl_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             accept_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == FULL_COUNT);
    assign do_pop   = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign accept_o = !full_o || do_pop;
    assign do_push  = push_i && accept_o;
    assign data_o   = empty_o ? '0 : mem_q[rd_ptr_q];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; the count gates visibility, so a reset here only costs routing.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/gate_link_node.sv
// Per-gate ring endpoint: serializes queued words on tx-start and deserializes the upstream stream.
module gate_link_node
    import gate_link_pkg::*;
#(
    parameter int DATA_WIDTH = GL_DATA_WIDTH,
    parameter int FIFO_DEPTH = GL_FIFO_DEPTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_gen_sync,
    input  logic                  i_tx_start,
    input  logic                  i_rx_pull,
    output logic                  o_tx_ready,
    output logic                  o_rx_ready,
    output logic                  o_tx_bit,
    output logic                  o_tx_frame,
    input  logic                  i_rx_bit,
    input  logic                  i_rx_frame,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_full,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    input  logic                  i_rx_read,
    output logic                  o_tx_underrun,
    output logic                  o_rx_overrun
);

    localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
    logic                  underrun_q, underrun_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d, hold_q, hold_d;
    logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
    logic                  ready_q, ready_d, overrun_q, overrun_d;

    logic [DATA_WIDTH-1:0] tx_head, rx_word;
    logic                  tx_empty, tx_pop, rx_empty, rx_accept;
    logic                  rx_done, pull_ok, rx_push;

    gl_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .push_i   (i_tx_valid),
        .data_i   (i_tx_data),
        .pop_i    (tx_pop),
        .data_o   (tx_head),
        .empty_o  (tx_empty),
        .full_o   (o_tx_full),
        .accept_o ()
    );

    gl_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .push_i   (rx_push),
        .data_i   (hold_q),
        .pop_i    (i_rx_read),
        .data_o   (o_rx_data),
        .empty_o  (rx_empty),
        .full_o   (),
        .accept_o (rx_accept)
    );

    assign rx_word = {rx_sh_q[DATA_WIDTH-2:0], i_rx_bit};
    assign rx_done = i_rx_frame && (rx_cnt_q == LAST_BIT) && !i_gen_sync;
    assign pull_ok = i_rx_pull && ready_q && !i_gen_sync;
    assign rx_push = pull_ok && rx_accept;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        tx_sh_d    = tx_sh_q;
        tx_cnt_d   = tx_cnt_q;
        tx_pop     = 1'b0;
        underrun_d = 1'b0;
        if (i_gen_sync) begin
            state_d  = TX_IDLE;
            tx_sh_d  = '0;
            tx_cnt_d = '0;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (i_tx_start) begin
                        state_d  = TX_SHIFT;
                        tx_cnt_d = '0;
                        if (tx_empty) begin
                            tx_sh_d    = GL_IDLE_WORD[DATA_WIDTH-1:0];
                            underrun_d = 1'b1;
                        end else begin
                            tx_sh_d = tx_head;
                            tx_pop  = 1'b1;
                        end
                    end
                end
                TX_SHIFT: begin
                    // Zero fill leaves the register clear once the frame ends, so the line idles low.
                    tx_sh_d = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
                    if (tx_cnt_q == LAST_BIT) begin
                        state_d  = TX_IDLE;
                        tx_cnt_d = '0;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 1'b1;
                    end
                end
                default: state_d = TX_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_sh_d   = rx_sh_q;
        rx_cnt_d  = rx_cnt_q;
        hold_d    = hold_q;
        ready_d   = ready_q;
        overrun_d = overrun_q;
        if (i_gen_sync) begin
            rx_cnt_d  = '0;
            ready_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            if (i_rx_frame) begin
                rx_sh_d  = rx_word;
                rx_cnt_d = (rx_cnt_q == LAST_BIT) ? '0 : rx_cnt_q + 1'b1;
            end else begin
                rx_cnt_d = '0;
            end
            if (pull_ok) begin
                ready_d = 1'b0;
                if (!rx_accept) overrun_d = 1'b1;
            end
            // A pull in the same cycle frees the holding register for the new word.
            if (rx_done) begin
                if (!ready_q || pull_ok) begin
                    hold_d  = rx_word;
                    ready_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= TX_IDLE;
            tx_sh_q    <= '0;
            tx_cnt_q   <= '0;
            underrun_q <= 1'b0;
            rx_sh_q    <= '0;
            rx_cnt_q   <= '0;
            hold_q     <= '0;
            ready_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sh_q    <= tx_sh_d;
            tx_cnt_q   <= tx_cnt_d;
            underrun_q <= underrun_d;
            rx_sh_q    <= rx_sh_d;
            rx_cnt_q   <= rx_cnt_d;
            hold_q     <= hold_d;
            ready_q    <= ready_d;
            overrun_q  <= overrun_d;
        end
    end

    assign o_tx_ready    = (state_q == TX_IDLE);
    assign o_tx_frame    = (state_q == TX_SHIFT);
    assign o_tx_bit      = tx_sh_q[DATA_WIDTH-1];
    assign o_tx_underrun = underrun_q;
    assign o_rx_ready    = ready_q;
    assign o_rx_overrun  = overrun_q;
    assign o_rx_valid    = !rx_empty;

endmodule

// File: tb/tb_gate_link_node.sv
// Loopback bench for gate_link_node: serial out feeds serial in, checked against a queue-level model.
module tb_gate_link_node;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_gen_sync = 1'b0, i_tx_start = 1'b0, i_rx_pull = 1'b0;
    logic          o_tx_ready, o_rx_ready, o_tx_bit, o_tx_frame;
    logic [DW-1:0] i_tx_data = '0;
    logic          i_tx_valid = 1'b0, o_tx_full;
    logic [DW-1:0] o_rx_data;
    logic          o_rx_valid, i_rx_read = 1'b0;
    logic          o_tx_underrun, o_rx_overrun;

    int total = 0;
    int bad   = 0;

    // Reference model: word queues plus the holding register and sticky overrun.
    logic [DW-1:0] txq[$];
    logic [DW-1:0] rxq[$];
    logic [DW-1:0] hold_w;
    bit            hold_v = 1'b0;
    bit            ovr    = 1'b0;

    gate_link_node #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_gen_sync    (i_gen_sync),
        .i_tx_start    (i_tx_start),
        .i_rx_pull     (i_rx_pull),
        .o_tx_ready    (o_tx_ready),
        .o_rx_ready    (o_rx_ready),
        .o_tx_bit      (o_tx_bit),
        .o_tx_frame    (o_tx_frame),
        .i_rx_bit      (o_tx_bit),
        .i_rx_frame    (o_tx_frame),
        .i_tx_data     (i_tx_data),
        .i_tx_valid    (i_tx_valid),
        .o_tx_full     (o_tx_full),
        .o_rx_data     (o_rx_data),
        .o_rx_valid    (o_rx_valid),
        .i_rx_read     (i_rx_read),
        .o_tx_underrun (o_tx_underrun),
        .o_rx_overrun  (o_rx_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_tx(input logic [DW-1:0] w);
        i_tx_data  = w;
        i_tx_valid = 1'b1;
        tick();
        i_tx_valid = 1'b0;
        if (txq.size() < DEPTH) txq.push_back(w);
        check("tx_full", o_tx_full, txq.size() == DEPTH);
    endtask

    // Start in cycle 0, bits in cycles 1..DW, both readies high in cycle DW+1.
    task automatic frame();
        logic [DW-1:0] w;
        bit            und;
        und = (txq.size() == 0);
        w   = und ? '0 : txq.pop_front();
        i_tx_start = 1'b1;
        tick();
        i_tx_start = 1'b0;
        for (int i = 0; i < DW; i++) begin
            if (i < 2) check("tx_underrun", o_tx_underrun, (i == 0) && und);
            check("tx_bit", o_tx_bit, w[DW-1-i]);
            check("tx_frame", o_tx_frame, 1);
            check("tx_ready_busy", o_tx_ready, 0);
            tick();
        end
        if (hold_v) ovr = 1'b1;
        else begin
            hold_w = w;
            hold_v = 1'b1;
        end
        check("tx_ready_end", o_tx_ready, 1);
        check("tx_frame_end", o_tx_frame, 0);
        check("rx_ready_end", o_rx_ready, 1);
        check("rx_overrun", o_rx_overrun, ovr);
    endtask

    task automatic pull();
        i_rx_pull = 1'b1;
        tick();
        i_rx_pull = 1'b0;
        if (hold_v) begin
            if (rxq.size() == DEPTH) ovr = 1'b1;
            else rxq.push_back(hold_w);
            hold_v = 1'b0;
        end
        check("rx_ready_pull", o_rx_ready, 0);
        check("rx_overrun_pull", o_rx_overrun, ovr);
        check("rx_valid_pull", o_rx_valid, rxq.size() != 0);
    endtask

    task automatic read_rx();
        check("rx_valid", o_rx_valid, rxq.size() != 0);
        if (rxq.size() != 0) check("rx_data", o_rx_data, rxq[0]);
        i_rx_read = 1'b1;
        tick();
        i_rx_read = 1'b0;
        if (rxq.size() != 0) void'(rxq.pop_front());
    endtask

    task automatic gen_sync();
        i_gen_sync = 1'b1;
        tick();
        i_gen_sync = 1'b0;
        hold_v = 1'b0;
        ovr    = 1'b0;
        check("sync_rx_ready", o_rx_ready, 0);
        check("sync_overrun", o_rx_overrun, 0);
        check("sync_tx_ready", o_tx_ready, 1);
    endtask

    initial begin
        tick();
        tick();
        i_rst = 1'b0;
        tick();

        // Reset state.
        check("rst_tx_ready", o_tx_ready, 1);
        check("rst_tx_frame", o_tx_frame, 0);
        check("rst_tx_bit", o_tx_bit, 0);
        check("rst_rx_ready", o_rx_ready, 0);
        check("rst_rx_valid", o_rx_valid, 0);
        check("rst_tx_full", o_tx_full, 0);
        check("rst_underrun", o_tx_underrun, 0);
        check("rst_overrun", o_rx_overrun, 0);
        check("rst_rx_data", o_rx_data, 0);

        // 0xA5 serialized MSB first, then committed and read back.
        push_tx(8'hA5);
        frame();
        pull();
        read_rx();

        // Loopback of two words.
        push_tx(8'h3C);
        push_tx(8'hC3);
        frame();
        pull();
        frame();
        pull();
        read_rx();
        read_rx();

        // Underrun sends the idle word; the next queued word still goes out intact.
        frame();
        pull();
        read_rx();
        push_tx(8'h5A);
        frame();
        pull();
        read_rx();

        // Two frames without a pull: overrun, first word kept.
        push_tx(8'h11);
        push_tx(8'h22);
        frame();
        frame();
        pull();
        read_rx();
        push_tx(8'h33);
        frame();
        gen_sync();

        // Sync in cycle 4 of a frame aborts both ends; that word is lost.
        push_tx(8'h96);
        push_tx(8'h69);
        i_tx_start = 1'b1;
        tick();
        i_tx_start = 1'b0;
        void'(txq.pop_front());
        tick();
        tick();
        tick();
        i_gen_sync = 1'b1;
        tick();
        i_gen_sync = 1'b0;
        check("abort_frame", o_tx_frame, 0);
        check("abort_tx_ready", o_tx_ready, 1);
        for (int i = 0; i < DW + 2; i++) begin
            check("abort_rx_ready", o_rx_ready, 0);
            tick();
        end
        frame();
        pull();
        read_rx();

        // RX FIFO full, then one more pull overruns without disturbing contents.
        push_tx(8'h01);
        push_tx(8'h02);
        push_tx(8'h03);
        push_tx(8'h04);
        push_tx(8'h05);
        for (int i = 0; i < DEPTH; i++) begin
            frame();
            pull();
        end
        frame();
        pull();
        read_rx();
        push_tx(8'hEE);
        frame();
        pull();
        while (rxq.size() != 0) read_rx();
        check("drained", o_rx_valid, 0);
        gen_sync();

        // Random mix of pushes, starts, pulls, reads and syncs against the model.
        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 2) != 0) push_tx(DW'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) != 0) push_tx(DW'($urandom_range(0, 255)));
            frame();
            if ($urandom_range(0, 3) != 0) pull();
            if (rxq.size() != 0 && $urandom_range(0, 1) != 0) read_rx();
            if ($urandom_range(0, 7) == 0) gen_sync();
        end
        if (hold_v) pull();
        while (rxq.size() != 0) read_rx();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
